ram_burst_ctrl: RTL and testbench

//  Initiator-side burst controller for the single-port RAM (we/re/addr/data_in -> registered data_out).
//  - Accepts one burst command at a time: write or read, start address, length.
//  - Streams write data in and read data out over valid/ready handshakes.
//  - Drives the RAM port and absorbs its 1-cycle read latency with a skid buffer.

---
 rtl/ram_ctrl_pkg.sv | 13 +
 rtl/ram_rd_skid_buf.sv | 51 +++++
 rtl/ram_burst_ctrl.sv | 128 ++++++++++++
 tb/tb_ram_burst_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// rtl/ram_ctrl_pkg.sv - shared types and constants for the RAM burst controller
package ram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    READ     = 2'd2,
    RD_DRAIN = 2'd3
  } state_t;

  localparam int RD_BUF_DEPTH = 2;

endpackage

// File: rtl/ram_rd_skid_buf.sv
// rtl/ram_rd_skid_buf.sv - 2-entry FIFO holding read beats and their last flag
module ram_rd_skid_buf
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  last_in,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  last_out,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] r_data [RD_BUF_DEPTH];
  logic                  r_last [RD_BUF_DEPTH];
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_occ;

  // The issuer never pushes into a full buffer, so push and pop need no guards here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_BUF_DEPTH; i++) begin
        r_data[i] <= '0;
        r_last[i] <= 1'b0;
      end
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_occ  <= 2'd0;
    end else begin
      if (push) begin
        r_data[r_wptr] <= din;
        r_last[r_wptr] <= last_in;
        r_wptr         <= ~r_wptr;
      end
      if (pop) begin
        r_rptr <= ~r_rptr;
      end
      r_occ <= r_occ + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout     = r_data[r_rptr];
  assign last_out = r_last[r_rptr];
  assign occ      = r_occ;

endmodule

// File: rtl/ram_burst_ctrl.sv
// rtl/ram_burst_ctrl.sv - burst controller driving a single-port RAM with streamed write/read beats
module ram_burst_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  done,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [LEN_WIDTH:0]    L_ONE = {{LEN_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] A_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH:0]    r_left;
  logic                  r_inflt;
  logic                  r_inflt_last;
  logic                  r_done;

  logic [1:0]            w_occ;
  logic                  w_pop;
  logic                  w_issue_ok;
  logic                  w_mem_re;
  logic                  w_buf_last;
  logic [DATA_WIDTH-1:0] w_buf_dout;

  assign w_pop      = rd_ready && (w_occ != 2'd0);
  // A read may only issue if its data is guaranteed a free buffer slot on arrival.
  assign w_issue_ok = ({1'b0, w_occ} + {2'b00, r_inflt}) < (3'd2 + {2'b00, w_pop});
  assign w_mem_re   = (r_state == READ) && (r_left != '0) && w_issue_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_left       <= '0;
      r_inflt      <= 1'b0;
      r_inflt_last <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_inflt      <= w_mem_re;
      r_inflt_last <= w_mem_re && (r_left == L_ONE);
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_addr  <= cmd_addr;
            r_left  <= {1'b0, cmd_len} + L_ONE;
            r_state <= cmd_write ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wr_valid) begin
            r_addr <= r_addr + A_ONE;
            r_left <= r_left - L_ONE;
            if (r_left == L_ONE) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        READ: begin
          if (w_mem_re) begin
            r_addr <= r_addr + A_ONE;
            r_left <= r_left - L_ONE;
            if (r_left == L_ONE) begin
              r_state <= RD_DRAIN;
            end
          end
        end
        RD_DRAIN: begin
          if (w_pop && w_buf_last) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  ram_rd_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (r_inflt),
    .pop     (w_pop),
    .din     (mem_rdata),
    .last_in (r_inflt_last),
    .dout    (w_buf_dout),
    .last_out(w_buf_last),
    .occ     (w_occ)
  );

  assign cmd_ready = (r_state == IDLE);
  assign wr_ready  = (r_state == WRITE);
  assign mem_we    = (r_state == WRITE) && wr_valid;
  assign mem_wdata = (r_state == WRITE) ? wr_data : '0;
  assign mem_re    = w_mem_re;
  assign mem_addr  = r_addr;
  assign rd_valid  = (w_occ != 2'd0);
  assign rd_data   = w_buf_dout;
  assign rd_last   = rd_valid && w_buf_last;
  assign done      = r_done;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// tb/tb_ram_burst_ctrl.sv - self-checking bench for ram_burst_ctrl with a behavioural RAM
module tb_ram_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [7:0]  cmd_addr = '0, cmd_len = '0;
  logic        wr_valid = 1'b0, wr_ready;
  logic [31:0] wr_data = '0;
  logic        rd_valid, rd_ready = 1'b1, rd_last, done;
  logic [31:0] rd_data;
  logic        mem_we, mem_re;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata = '0;

  always #5 clk = ~clk;

  ram_burst_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .LEN_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done(done),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [31:0] ram [256];
  initial for (int i = 0; i < 256; i++) ram[i] = '0;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: burst bookkeeping from the handshakes plus an image of intended memory contents.
  typedef struct { logic [31:0] d; logic last; } beat_t;
  logic [31:0] model_mem [256];
  initial for (int i = 0; i < 256; i++) model_mem[i] = '0;
  beat_t       rq[$];
  beat_t       b;
  bit          m_busy = 0, m_wr = 0, m_done_exp = 0, p_pop;
  logic [7:0]  m_addr = '0;
  int          m_left = 0, m_out = 0;

  logic [7:0]  wr_addr_log[$], re_addr_log[$];
  logic [31:0] rd_dat_log[$];
  logic        rd_lst_log[$];
  int          wr_cyc[$], re_cyc[$], rd_hs_cyc[$];
  int          cmd_cyc = 0, rdv_first = -1, done_cyc = -1;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_re", mem_re, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_done", done, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      m_busy = 0; m_done_exp = 0; m_out = 0;
      rq.delete();
    end else begin
      chk("done", done, m_done_exp);
      m_done_exp = 0;
      if (done) done_cyc = cyc;
      chk("cmd_ready", cmd_ready, !m_busy);
      chk("wr_ready", wr_ready, m_busy && m_wr);
      chk("we_re_exclusive", mem_we && mem_re, 0);
      if (rd_valid && rdv_first < 0) rdv_first = cyc;
      p_pop = rd_valid && rd_ready;
      if (!m_busy) begin
        chk("idle_mem_we", mem_we, 0);
        chk("idle_mem_re", mem_re, 0);
        chk("idle_rd_valid", rd_valid, 0);
        if (cmd_valid) begin
          m_busy = 1; m_wr = cmd_write; m_addr = cmd_addr;
          m_left = int'(cmd_len) + 1; m_out = 0; cmd_cyc = cyc;
          if (!cmd_write)
            for (int k = 0; k < m_left; k++)
              rq.push_back('{d: model_mem[8'(int'(cmd_addr) + k)], last: (k == m_left - 1)});
        end
      end else if (m_wr) begin
        chk("wr_mem_we", mem_we, wr_valid);
        chk("wr_mem_re", mem_re, 0);
        if (wr_valid) begin
          chk("wr_mem_addr", mem_addr, m_addr);
          chk("wr_mem_wdata", mem_wdata, wr_data);
          model_mem[m_addr] = wr_data;
          wr_addr_log.push_back(mem_addr);
          wr_cyc.push_back(cyc);
          m_addr++; m_left--;
          if (m_left == 0) begin m_busy = 0; m_done_exp = 1; end
        end
      end else begin
        chk("rd_mem_we", mem_we, 0);
        if (mem_re) begin
          chk("re_mem_addr", mem_addr, m_addr);
          chk("re_beats_remain", m_left > 0, 1);
          re_addr_log.push_back(mem_addr);
          re_cyc.push_back(cyc);
          m_addr++; m_left--; m_out++;
        end
        if (p_pop) begin
          if (rq.size() == 0) begin
            chk("rd_unexpected_beat", 1, 0);
          end else begin
            b = rq.pop_front();
            chk("rd_data", rd_data, b.d);
            chk("rd_last", rd_last, b.last);
            rd_dat_log.push_back(rd_data);
            rd_lst_log.push_back(rd_last);
            rd_hs_cyc.push_back(cyc);
            m_out--;
            if (b.last) begin m_busy = 0; m_done_exp = 1; end
          end
        end
        chk("rd_outstanding_le2", m_out <= 2, 1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_addr_log.delete(); re_addr_log.delete(); rd_dat_log.delete(); rd_lst_log.delete();
    wr_cyc.delete(); re_cyc.delete(); rd_hs_cyc.delete();
    rdv_first = -1; done_cyc = -1;
  endtask

  task automatic do_cmd(input logic wr, input logic [7:0] a, input logic [7:0] l);
    int bud = 0;
    while (!cmd_ready && bud < 300) begin step(); bud++; end
    if (!cmd_ready) chk("cmd_ready_timeout", 0, 1);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_len = l;
    step();
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
  endtask

  task automatic wait_done();
    int bud = 0;
    while (!done && bud < 300) begin step(); bud++; end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic do_write(input logic [7:0] a, input int l, input int base, input int gap_at);
    do_cmd(1'b1, a, 8'(l));
    for (int i = 0; i <= l; i++) begin
      if (i == gap_at) begin wr_valid = 0; step(); end
      wr_valid = 1; wr_data = 32'(base + i);
      step();
    end
    wr_valid = 0; wr_data = '0;
    wait_done();
    step();
  endtask

  task automatic do_read(input logic [7:0] a, input int l, input int lo, input int hi);
    int j = 1;
    rd_ready = 1;
    do_cmd(1'b0, a, 8'(l));
    while (!done && j < 300) begin
      rd_ready = !(j >= lo && j <= hi);
      step();
      j++;
    end
    if (!done) chk("rd_done_timeout", 0, 1);
    rd_ready = 1;
    step();
  endtask

  initial begin
    int n;
    // Reset held with inputs toggling
    rst_n = 0;
    for (int i = 0; i < 3; i++) begin
      cmd_valid = ~cmd_valid; cmd_write = 1; wr_valid = ~wr_valid; rd_ready = ~rd_ready;
      wr_data = 32'hDEAD0000 + 32'(i);
      step();
      chk("t1_cmd_ready", cmd_ready, 1);
      chk("t1_mem_addr", mem_addr, 0);
      chk("t1_rd_data", rd_data, 0);
    end
    cmd_valid = 0; cmd_write = 0; wr_valid = 0; rd_ready = 1; wr_data = '0;
    rst_n = 1;
    step();

    // Write 0x10 len 3
    clear_logs();
    do_write(8'h10, 3, 32'hA0, -1);
    chk("t2_n_writes", wr_addr_log.size(), 4);
    for (int i = 0; i < 4 && i < wr_addr_log.size(); i++) chk("t2_wr_addr", wr_addr_log[i], 32'h10 + 32'(i));
    if (wr_cyc.size() == 4) begin
      chk("t2_consecutive", wr_cyc[3] - wr_cyc[0], 3);
      chk("t2_done_cycle", done_cyc, wr_cyc[3] + 1);
    end

    // Read 0x10 len 3, no stall
    clear_logs();
    do_read(8'h10, 3, 1, 0);
    chk("t3_latency", rdv_first - cmd_cyc, 3);
    chk("t3_n_beats", rd_dat_log.size(), 4);
    for (int i = 0; i < 4 && i < rd_dat_log.size(); i++) begin
      chk("t3_data", rd_dat_log[i], 32'hA0 + 32'(i));
      chk("t3_last", rd_lst_log[i], (i == 3) ? 32'd1 : 32'd0);
    end
    if (rd_hs_cyc.size() == 4) begin
      chk("t3_consecutive", rd_hs_cyc[3] - rd_hs_cyc[0], 3);
      chk("t3_done_cycle", done_cyc, rd_hs_cyc[3] + 1);
    end

    // Read len 7 with rd_ready low N+2..N+9
    do_write(8'h40, 7, 32'hB0, -1);
    clear_logs();
    do_read(8'h40, 7, 2, 9);
    n = 0;
    foreach (re_cyc[i]) if (re_cyc[i] - cmd_cyc <= 9) n++;
    chk("t4_reads_before_release", n, 2);
    chk("t4_n_beats", rd_dat_log.size(), 8);
    for (int i = 0; i < 8 && i < rd_dat_log.size(); i++) chk("t4_data", rd_dat_log[i], 32'hB0 + 32'(i));

    // Address wrap at 0xFE
    clear_logs();
    do_write(8'hFE, 3, 32'hC0, 2);
    chk("t5_n_writes", wr_addr_log.size(), 4);
    if (wr_addr_log.size() == 4) begin
      chk("t5_wa0", wr_addr_log[0], 32'hFE); chk("t5_wa1", wr_addr_log[1], 32'hFF);
      chk("t5_wa2", wr_addr_log[2], 32'h00); chk("t5_wa3", wr_addr_log[3], 32'h01);
    end
    clear_logs();
    do_read(8'hFE, 3, 3, 4);
    chk("t5_n_reads", re_addr_log.size(), 4);
    if (re_addr_log.size() == 4) begin
      chk("t5_ra0", re_addr_log[0], 32'hFE); chk("t5_ra1", re_addr_log[1], 32'hFF);
      chk("t5_ra2", re_addr_log[2], 32'h00); chk("t5_ra3", re_addr_log[3], 32'h01);
    end
    for (int i = 0; i < 4 && i < rd_dat_log.size(); i++) chk("t5_data", rd_dat_log[i], 32'hC0 + 32'(i));

    // Reset mid read burst, then a clean write/read
    clear_logs();
    rd_ready = 1;
    do_cmd(1'b0, 8'h40, 8'd7);
    n = 0;
    while (rd_dat_log.size() < 2 && n < 50) begin step(); n++; end
    chk("t6_two_beats_seen", rd_dat_log.size(), 2);
    #2 rst_n = 0;
    #1;
    chk("t6_cmd_ready", cmd_ready, 1);
    chk("t6_rd_valid", rd_valid, 0);
    chk("t6_mem_re", mem_re, 0);
    chk("t6_rd_last", rd_last, 0);
    chk("t6_mem_addr", mem_addr, 0);
    chk("t6_rd_data", rd_data, 0);
    step(); step();
    rst_n = 1;
    step();
    clear_logs();
    do_write(8'h20, 1, 32'hD0, -1);
    chk("t6_n_writes", wr_addr_log.size(), 2);
    if (wr_addr_log.size() == 2) begin
      chk("t6_wa0", wr_addr_log[0], 32'h20);
      chk("t6_wa1", wr_addr_log[1], 32'h21);
      chk("t6_done_cycle", done_cyc, wr_cyc[1] + 1);
    end
    clear_logs();
    do_read(8'h20, 1, 1, 0);
    chk("t6_n_beats", rd_dat_log.size(), 2);
    for (int i = 0; i < 2 && i < rd_dat_log.size(); i++) chk("t6_data", rd_dat_log[i], 32'hD0 + 32'(i));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
